// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// Debounced, press-driven saturating down counter. Two raw push-buttons are
// each passed through a 2-FF synchronizer, a stability-counter debouncer and a
// rising-edge detector. A `down` press decrements `count` (saturating at zero),
// and a `load` press reloads LOAD_VALUE. `load` takes priority when both
// presses land in the same cycle.
//
// Parameters:
//   WIDTH      - width of count
//   DB_CYCLES  - consecutive stable synchronized samples (>=2) before the
//                debounced level follows the input
//   LOAD_VALUE - value loaded on reset and on a load press (< 2**WIDTH)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   down       in   raw asynchronous bouncy decrement button, active-high
//   load       in   raw asynchronous bouncy reload button, active-high
//   count      out  current count (registered)
//   zero       out  high while count == 0
//   underflow  out  one-cycle pulse when a down press arrives at count == 0
// -----------------------------------------------------------------------------
module down_counter #(
    parameter int WIDTH      = 3,
    parameter int DB_CYCLES  = 16,
    parameter int LOAD_VALUE = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             down,
    input  logic             load,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             underflow
);

    // Stability counter only needs to reach DB_CYCLES-1.
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]    DB_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(LOAD_VALUE);

    // Button index 0 = down, 1 = load.
    logic [1:0] raw;
    logic [1:0] press;

    assign raw = {load, down};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          db_reg;
            logic          db_prev_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    db_reg      <= 1'b0;
                    db_prev_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= raw[gi];
                    sync2_reg   <= sync1_reg;
                    db_prev_reg <= db_reg;
                    // Any sample matching the current debounced level restarts
                    // the stability window, so bounces never accumulate.
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        db_reg  <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            // Rising edge of the debounced level only; releases are ignored.
            assign press[gi] = db_reg & ~db_prev_reg;
        end
    endgenerate

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             underflow_reg;
    logic             underflow_next;

    always_comb begin
        count_next     = count_reg;
        underflow_next = 1'b0;
        if (press[1]) begin
            count_next = LOAD_VAL;
        end else if (press[0]) begin
            if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end else begin
                // Saturate at zero and flag the lost press.
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= LOAD_VAL;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            underflow_reg <= underflow_next;
        end
    end

    assign count     = count_reg;
    assign underflow = underflow_reg;
    assign zero      = (count_reg == '0);

endmodule

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
//
// Directed and random stimulus for down_counter (WIDTH=3, DB_CYCLES=4,
// LOAD_VALUE=7). A reference model derives the debounced levels from a sliding
// window over the synchronized raw-sample history and applies the counting
// rules with plain arithmetic; every cycle the DUT outputs are compared to it.
// -----------------------------------------------------------------------------
module tb_down_counter;

    localparam int W   = 3;
    localparam int DB  = 4;
    localparam int LV  = 7;
    localparam int HMAX = 8192;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         down = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] count;
    logic         zero;
    logic         underflow;

    int n_asserts = 0;
    int n_fails   = 0;
    int uf_seen   = 0;

    // Model state: raw samples and debounced level per edge since reset.
    bit raw_hist [2][HMAX];
    bit db_hist  [2][HMAX];
    int k_edge   = 0;
    int m_count  = LV;
    bit m_under  = 1'b0;

    down_counter #(
        .WIDTH     (W),
        .DB_CYCLES (DB),
        .LOAD_VALUE(LV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .down     (down),
        .load     (load),
        .count    (count),
        .zero     (zero),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic d, input logic l, input logic r);
        bit rv [2];
        bit pr [2];
        bit db_last;
        bit db_last2;
        bit flip;
        bit s2;
        if (r) begin
            k_edge  = 0;
            m_count = LV;
            m_under = 1'b0;
            return;
        end
        if (k_edge >= HMAX - 1) begin
            $display("FAIL model_history edges=%0d limit=%0d", k_edge, HMAX);
            $fatal(1, "history overflow");
        end
        rv[0] = d;
        rv[1] = l;
        for (int b = 0; b < 2; b++) begin
            db_last  = (k_edge >= 1) ? db_hist[b][k_edge-1] : 1'b0;
            db_last2 = (k_edge >= 2) ? db_hist[b][k_edge-2] : 1'b0;
            pr[b]    = db_last & ~db_last2;
            raw_hist[b][k_edge] = rv[b];
            // Level flips once the synchronized input (raw delayed two edges)
            // has disagreed with it for DB consecutive edges.
            flip = 1'b0;
            if (k_edge - DB + 1 >= 0) begin
                flip = 1'b1;
                for (int j = k_edge - DB + 1; j <= k_edge; j++) begin
                    s2 = (j >= 2) ? raw_hist[b][j-2] : 1'b0;
                    if (s2 == db_last) flip = 1'b0;
                end
            end
            db_hist[b][k_edge] = flip ? ~db_last : db_last;
        end
        k_edge++;
        if (pr[1]) begin
            m_count = LV;
            m_under = 1'b0;
        end else if (pr[0] && m_count != 0) begin
            m_count = m_count - 1;
            m_under = 1'b0;
        end else if (pr[0]) begin
            m_under = 1'b1;
        end else begin
            m_under = 1'b0;
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, model the edge, compare 1 time unit after.
    task automatic step(input logic d, input logic l, input logic r);
        @(negedge clk);
        down = d;
        load = l;
        rst  = r;
        @(posedge clk);
        model_edge(d, l, r);
        #1;
        if (underflow === 1'b1) uf_seen++;
        n_asserts++;
        assert (count === W'(m_count)) else begin
            n_fails++;
            $error("FAIL count observed=%0d expected=%0d", count, m_count);
        end
        n_asserts++;
        assert (zero === (m_count == 0)) else begin
            n_fails++;
            $error("FAIL zero observed=%b expected=%b", zero, (m_count == 0));
        end
        n_asserts++;
        assert (underflow === m_under) else begin
            n_fails++;
            $error("FAIL underflow observed=%b expected=%b", underflow, m_under);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_down();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        idle(10);
    endtask

    task automatic press_load();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        idle(10);
    endtask

    int bounce_pat [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int uf_before;
    int r_len;
    logic r_d;
    logic r_l;

    initial begin
        // Reset and idle hold.
        step(1'b0, 1'b0, 1'b1);
        check_int("reset_count", int'(count), 7);
        check_int("reset_zero", int'(zero), 0);
        check_int("reset_underflow", int'(underflow), 0);
        idle(50);
        check_int("idle_count", int'(count), 7);

        // Clean press: count changes exactly 6 edges after E0.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 5) check_int("clean_before_latency", int'(count), 7);
            if (i == 6) check_int("clean_at_latency", int'(count), 6);
        end
        idle(20);
        check_int("clean_after_release", int'(count), 6);

        // Bounce then stable high: one decrement.
        for (int i = 0; i < 8; i++) step(bounce_pat[i] != 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        idle(20);
        check_int("bounce_single_dec", int'(count), 5);

        // Short glitch: ignored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        idle(20);
        check_int("glitch_ignored", int'(count), 5);

        // Saturation: reload, 7 presses to zero, 8th underflows once.
        press_load();
        check_int("load_restore", int'(count), 7);
        for (int p = 0; p < 7; p++) press_down();
        check_int("sat_count", int'(count), 0);
        check_int("sat_zero", int'(zero), 1);
        uf_before = uf_seen;
        press_down();
        check_int("sat_hold", int'(count), 0);
        check_int("underflow_pulses", uf_seen - uf_before, 1);

        // Simultaneous load and down at count=3: load wins.
        press_load();
        for (int p = 0; p < 4; p++) press_down();
        check_int("pre_simul_count", int'(count), 3);
        uf_before = uf_seen;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        idle(10);
        check_int("simul_load_wins", int'(count), 7);
        check_int("simul_no_underflow", uf_seen - uf_before, 0);
        press_down();
        check_int("after_simul_down", int'(count), 6);

        // Reset mid-debounce with down held throughout.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_int("middb_reset_count", int'(count), 7);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 5) check_int("middb_before_latency", int'(count), 7);
            if (i == 6) check_int("middb_at_latency", int'(count), 6);
        end
        idle(10);

        // Random bursts of bouncy/stable levels on both buttons, rare resets.
        for (int seg = 0; seg < 200; seg++) begin
            r_len = $urandom_range(1, 12);
            r_d   = ($urandom_range(0, 1) == 1);
            r_l   = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < r_len; i++) begin
                step(($urandom_range(0, 9) == 0) ? ~r_d : r_d,
                     ($urandom_range(0, 9) == 0) ? ~r_l : r_l,
                     ($urandom_range(0, 199) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Debounced, press-driven saturating down counter: the decrementing counterpart of the team's up-counter demo block.
- Two raw push-buttons are handled internally:
  - `down` decrements `count` once per press.
  - `load` reloads `count` to a preset value.
- Each button goes through a 2-FF synchronizer, a stability-counter debouncer and a rising-edge detector.
- Sits between board push-buttons and the 7-segment/LED display logic; `zero` and `underflow` feed status LEDs.

Parameters:
- WIDTH, 3: width of `count`.
- DB_CYCLES, 16: consecutive stable synchronized samples (>=2) required before a debounced level changes.
- LOAD_VALUE, 7: value loaded on reset and on a `load` press. Must be < 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- down  input  1  raw, asynchronous, bouncy decrement button; active-high.
- load  input  1  raw, asynchronous, bouncy reload button; active-high.
- count  output  WIDTH  current count (registered).
- zero  output  1  high when `count` == 0 (decoded from the `count` register, no extra latency).
- underflow  output  1  one-cycle pulse when a `down` press arrives while `count` == 0.

Behaviour:
- Reset (rst=1 at rising edge) sets:
  - `count` = LOAD_VALUE, `underflow` = 0.
  - Synchronizer flops, debounced levels, edge-detect history and stability counters all = 0.
  - Reset overrides every other event; asserting it mid-debounce discards the partial count.
- Synchronizer, per button:
  - sync1 <= raw, then sync2 <= sync1.
- Debouncer, per button (independent instances). Stability counter width is ceil(log2(DB_CYCLES)).
  - If sync2 == db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the current db level restarts the count.
- Edge detect:
  - db_prev <= db.
  - A press is db & ~db_prev, high for exactly one cycle per debounced rising edge.
  - Releases (falling edges) produce no event.
  - A held button produces exactly one press.
- Latency: take E0 as the first edge that samples a clean high on `down`.
  - db goes high after edge E(DB_CYCLES+1).
  - `count` updates at edge E(DB_CYCLES+2).
  - `load` has identical latency.
- Count update, evaluated at each rising edge using this cycle's press pulses:
  - load_press: count <= LOAD_VALUE; underflow <= 0. This applies regardless of down_press, so load wins on a simultaneous press.
  - Else down_press and count != 0: count <= count-1; underflow <= 0.
  - Else down_press and count == 0: count stays 0 (saturate, no wrap to 2^WIDTH-1); underflow <= 1 for one cycle.
  - Else: count holds; underflow <= 0.
- Button held through reset release: db restarts at 0, so one press is generated DB_CYCLES+2 edges after reset deasserts.

Test Plan (bench uses DB_CYCLES=4, WIDTH=3, LOAD_VALUE=7):
- Reset: pulse rst 1 cycle -> count=7, zero=0, underflow=0 on the next cycle. Raw buttons idle -> count stays 7 for 50 cycles.
- Clean press: hold `down` high 20 cycles, then low -> count=6 exactly 6 edges after the first sampled-high edge. No change on release or while held.
- Bounce rejection:
  - `down` toggles 1,0,1,0 every 2 cycles, then stays high -> exactly one decrement.
  - Glitch high for 3 cycles only -> no decrement.
- Saturation: 7 clean presses -> count 7 to 0, zero=1. 8th press -> count stays 0, underflow high for exactly 1 cycle.
- Load/down simultaneous: `load` and `down` asserted on the same edge with count=3 -> count=7 after latency, underflow=0. Next `down` press -> count=6.
- Reset mid-debounce: `down` high, rst at cycle 3 of debounce, `down` still held -> count=7 after reset, then count=6 at 6 edges after reset deasserts.
